// File: rtl/fwft_fifo_pkg.sv
// rtl/fwft_fifo_pkg.sv - shared widths and state type for the fwft_fifo read/write front ends
package fwft_fifo_pkg;

  localparam int WIDTH    = 36;
  localparam int LAST_BIT = 32;
  localparam int CNT_W    = 16;

  // EMPTY: nothing held, ONE: output register valid, TWO: output and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/fwft_fifo_wr_stats.sv
// rtl/fwft_fifo_wr_stats.sv - free-running FIFO write and end-of-packet counters
module fwft_fifo_wr_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drain,
  input  logic             last,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] pkt_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (drain) begin
        word_count <= word_count + 1'b1;
      end
      if (drain && last) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwft_fifo_writer.sv
// rtl/fwft_fifo_writer.sv - valid/ready to FIFO write front end with 2-entry skid buffer
module fwft_fifo_writer
  import fwft_fifo_pkg::*;
#(
  parameter int WIDTH    = fwft_fifo_pkg::WIDTH,
  parameter int LAST_BIT = fwft_fifo_pkg::LAST_BIT,
  parameter int CNT_W    = fwft_fifo_pkg::CNT_W
) (
  input  logic             wr_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] fifo_din,
  output logic             fifo_wr_en,
  input  logic             fifo_full,
  input  logic             fifo_prog_full,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] pkt_count
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             pf_q;
  logic             accept;
  logic             drain;

  // pf_q resets high so nothing is accepted until prog_full has been seen once
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
      pf_q   <= 1'b1;
    end else begin
      state <= state_nxt;
      pf_q  <= fifo_prog_full;
      case (state)
        EMPTY: begin
          if (accept) out_q <= s_data;
        end
        ONE: begin
          if (accept && drain) out_q <= s_data;
          else if (accept) skid_q <= s_data;
        end
        TWO: begin
          if (drain) out_q <= skid_q;
        end
        default: begin
          out_q <= out_q;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = ONE;
      end
      ONE: begin
        if (accept && !drain) state_nxt = TWO;
        else if (!accept && drain) state_nxt = EMPTY;
      end
      TWO: begin
        if (drain) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Ready depends only on flops; full gates the write strobe combinationally
  always_comb begin
    s_ready    = (state != TWO) && !pf_q;
    fifo_wr_en = (state != EMPTY) && !fifo_full;
    accept     = s_valid && s_ready;
    drain      = fifo_wr_en;
    fifo_din   = out_q;
  end

  fwft_fifo_wr_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (wr_clk),
    .rst_n     (rst_n),
    .drain     (drain),
    .last      (out_q[LAST_BIT]),
    .word_count(word_count),
    .pkt_count (pkt_count)
  );

endmodule
